// File: rtl/urna_pkg.sv
// urna_pkg: shared state encoding, digit limit and default candidate codes for the ballot.
package urna_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        REVIEW = 2'd2,
        CLOSED = 2'd3
    } state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [63:0] CAND_CODES_DEF = {16'h3504, 16'h3472, 16'h3485, 16'h3494};
endpackage

// File: rtl/urna_ballot_param_code_match.sv
// urna_code_match: compares the held code with every candidate code, lowest index wins.
module urna_code_match #(
    parameter int NUM_CAND = 4,
    parameter int CODE_DIGITS = 4,
    parameter int IDX_W = 2,
    parameter logic [NUM_CAND*CODE_DIGITS*4-1:0] CAND_CODES = '0
) (
    input  logic [CODE_DIGITS*4-1:0] code,
    output logic                     hit,
    output logic [IDX_W-1:0]         idx
);
    localparam int CW = CODE_DIGITS * 4;
    always_comb begin
        hit = 1'b0;
        idx = '0;
        // descending scan so the lowest matching index is the one left standing
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (code == CAND_CODES[i*CW +: CW]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/urna_ballot_param.sv
// urna_ballot_param: keypad-driven ballot FSM with saturating tallies for candidates, null and blank votes.
module urna_ballot_param import urna_pkg::*; #(
    parameter int NUM_CAND = 4,
    parameter int CODE_DIGITS = 4,
    parameter int CNT_W = 8,
    parameter logic [NUM_CAND*CODE_DIGITS*4-1:0] CAND_CODES = CAND_CODES_DEF
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [3:0]                Digit,
    input  logic                      Valid,
    input  logic                      Confirm,
    input  logic                      Cancel,
    input  logic                      Finish,
    output logic [NUM_CAND*CNT_W-1:0] Votes,
    output logic [CNT_W-1:0]          Nulo,
    output logic [CNT_W-1:0]          Branco,
    output logic                      Status,
    output logic                      Busy,
    output logic                      Closed,
    output logic                      Overflow
);
    localparam int CW = CODE_DIGITS * 4;
    localparam int NT = NUM_CAND + 2;
    localparam int IDX_W = NUM_CAND > 1 ? $clog2(NUM_CAND) : 1;
    localparam int CNT_DW = $clog2(CODE_DIGITS + 1);

    state_t state_q, state_d;
    logic [CNT_DW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] code_q, code_d;
    logic bad_q, bad_d, status_q, status_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] tally_q [NT];
    logic [CNT_W-1:0] tally_d [NT];
    logic [NT-1:0] inc, sat;
    logic hit, good, fin, can, act, val, vote_blank, vote_rev, clr, full;
    logic [IDX_W-1:0] idx;

    urna_code_match #(
        .NUM_CAND(NUM_CAND),
        .CODE_DIGITS(CODE_DIGITS),
        .IDX_W(IDX_W),
        .CAND_CODES(CAND_CODES)
    ) u_match (
        .code(code_q),
        .hit(hit),
        .idx(idx)
    );

    always_comb begin
        fin = Finish && state_q != CLOSED;
        can = !Finish && Cancel && (state_q == ENTRY || state_q == REVIEW);
        act = !Finish && !Cancel;
        vote_blank = act && Confirm && state_q == IDLE;
        vote_rev = act && Confirm && state_q == REVIEW;
        val = act && !Confirm && Valid && (state_q == IDLE || state_q == ENTRY);
        clr = fin || can || vote_blank || vote_rev;
        full = cnt_q + 1'b1 == CNT_DW'(CODE_DIGITS);
        cnt_d = clr ? '0 : val ? cnt_q + 1'b1 : cnt_q;
        code_d = clr ? '0 : val ? (code_q << 4) | CW'(Digit) : code_q;
        bad_d = clr ? 1'b0 : bad_q | (val && Digit > BCD_MAX);
        state_d = fin ? CLOSED : clr ? IDLE : val ? (full ? REVIEW : ENTRY) : state_q;
        good = hit && !bad_q;
        inc = '0;
        for (int i = 0; i < NUM_CAND; i++) inc[i] = vote_rev && good && idx == IDX_W'(i);
        inc[NUM_CAND] = vote_rev && !good;
        inc[NUM_CAND+1] = vote_blank;
        status_d = vote_blank || vote_rev;
        ovf_d = ovf_q || |(inc & sat);
    end

    // slots NUM_CAND and NUM_CAND+1 hold the null and blank tallies
    for (genvar g = 0; g < NT; g++) begin : g_cnt
        assign sat[g] = &tally_q[g];
        assign tally_d[g] = (inc[g] && !sat[g]) ? tally_q[g] + 1'b1 : tally_q[g];
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_out
        assign Votes[g*CNT_W +: CNT_W] = tally_q[g];
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            code_q <= '0;
            bad_q <= 1'b0;
            status_q <= 1'b0;
            ovf_q <= 1'b0;
            for (int i = 0; i < NT; i++) tally_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            code_q <= code_d;
            bad_q <= bad_d;
            status_q <= status_d;
            ovf_q <= ovf_d;
            tally_q <= tally_d;
        end
    end

    assign Nulo = tally_q[NUM_CAND];
    assign Branco = tally_q[NUM_CAND+1];
    assign Status = status_q;
    assign Busy = state_q == ENTRY || state_q == REVIEW;
    assign Closed = state_q == CLOSED;
    assign Overflow = ovf_q;
endmodule

// File: doc/urna_ballot_param.md
Name: urna_ballot_param

Overview:
- Parametrised successor to the fixed four-candidate ballot FSM.
- Takes keypad digits one at a time with a Valid strobe, assembles a CODE_DIGITS-digit BCD code and holds it for review.
- On Confirm, credits the matching candidate counter, or the null counter if nothing matches; Confirm with no digits entered credits the blank counter.
- Adds Cancel (correction), blank votes, saturating counters, an overflow flag and a sticky close on Finish. Sits between the keypad debouncer and the tally display/readout logic.

Parameters:
- NUM_CAND, 4, number of candidates (1..16).
- CODE_DIGITS, 4, BCD digits per candidate code (1..8).
- CNT_W, 8, width of every tally counter.
- CAND_CODES, {16'h3504,16'h3472,16'h3485,16'h3494}, packed BCD codes, NUM_CAND*CODE_DIGITS*4 bits. Candidate 0 occupies the LSBs; the most significant digit of each code is the one entered first.

Ports:
- Clock, input, 1, system clock, rising edge.
- Reset_n, input, 1, asynchronous active-low reset.
- Digit, input, 4, BCD keypad digit; values 10..15 are illegal.
- Valid, input, 1, Digit qualifier, one cycle per keypress.
- Confirm, input, 1, casts the reviewed vote.
- Cancel, input, 1, discards the digits entered so far.
- Finish, input, 1, closes the election.
- Votes, output, NUM_CAND*CNT_W, candidate tallies; candidate i is at [i*CNT_W +: CNT_W].
- Nulo, output, CNT_W, null-vote tally.
- Branco, output, CNT_W, blank-vote tally.
- Status, output, 1, one-cycle pulse when a vote is recorded.
- Busy, output, 1, high when state is ENTRY or REVIEW.
- Closed, output, 1, high when state is CLOSED.
- Overflow, output, 1, sticky flag: some counter saturated.
- Reset: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (Reset_n=0, asynchronous): all tallies 0, Status 0, Overflow 0, state IDLE, digit count 0, shift register 0, bad-digit flag 0.
- States:
  - IDLE: no digits entered.
  - ENTRY: 1..CODE_DIGITS-1 digits entered.
  - REVIEW: CODE_DIGITS digits held, waiting for Confirm or Cancel.
  - CLOSED: terminal until Reset_n.
- Input priority per cycle: Finish > Cancel > Confirm > Valid. Only the highest-priority asserted input acts.
- Finish in any state: next state CLOSED, pending digits discarded, no vote recorded. In CLOSED all inputs are ignored and tallies are frozen.
- Valid in IDLE/ENTRY: shift Digit into the code register (left shift, new digit in the LSBs) and increment the digit count.
  - If Digit > 9, set the bad-digit flag.
  - When the count reaches CODE_DIGITS, move to REVIEW; otherwise move to or stay in ENTRY.
- Valid in REVIEW: ignored. Extra digits never overwrite the held code.
- Cancel in ENTRY/REVIEW: clear count, shift register and bad flag; go to IDLE. No vote recorded. Cancel in IDLE has no effect.
- Confirm:
  - In IDLE: Branco += 1.
  - In ENTRY: ignored (incomplete code).
  - In REVIEW: if the bad flag is clear and the code equals CAND_CODES[i], Votes[i] += 1. If several codes are equal, the lowest i wins. Otherwise Nulo += 1.
  - Both recording cases then go to IDLE with digits cleared.
- Latency: a tally updates on the same rising edge that samples Confirm. Status is high for exactly the following cycle. Back-to-back votes are possible, so Status may stay high on consecutive cycles.
- Saturation: a counter at 2^CNT_W-1 holds its value. The attempted increment still pulses Status and sets Overflow, which stays set until Reset_n.
- Reset_n asserted mid-entry or mid-vote: immediate clear, with no partial commit.
- Unused or illegal state encodings recover to IDLE.

Decomposition:
- Shared package urna_pkg holds:
  - the state enum (IDLE, ENTRY, REVIEW, CLOSED);
  - the digit constant BCD_MAX=9;
  - the default CAND_CODES localparam.
- One sub-module, urna_code_match: purely combinational.
  - Inputs: the held code and CAND_CODES.
  - Outputs: hit and a $clog2(NUM_CAND)-bit index with lowest-index priority.
- Counters stay inline in the top module as generate-loop instances of the saturating increment.

Test Plan:
- Reset then digits 3,4,9,4 + Confirm -> Votes[0]=1, one Status pulse on the cycle after Confirm, other tallies 0.
- Digits 3,5,0,4 + Confirm; then 3,4,7,2 + Confirm -> Votes[3]=1, Votes[2]=1.
- Digits 3,4,1,1 + Confirm -> Nulo=1. Digits 3,4,A,4 + Confirm -> Nulo=2 (bad digit). Confirm in IDLE -> Branco=1.
- Digits 3,4 + Cancel, then 3,4,8,5 + Confirm -> Votes[1]=1, no Nulo. Confirm after 2 digits -> no change, Busy stays 1.
- CNT_W=2: four votes for 3494 -> Votes[0]=3, Overflow=1, four Status pulses.
- Digits 3,4,9 then Finish+Confirm in the same cycle -> Closed=1, tallies unchanged, later Valid/Confirm ignored. Reset_n low mid-entry -> all outputs 0 asynchronously.
